// File: rtl/ipu_pkg.sv
// ipu_pkg: shared types, field indices and helpers for the multi-colour centroid path
package ipu_pkg;
  typedef struct packed {
    logic [11:0] Rmin;
    logic [11:0] Rmax;
    logic [11:0] Gmin;
    logic [11:0] Gmax;
    logic [11:0] Bmin;
    logic [11:0] Bmax;
  } rgb_thresh_t;
  typedef enum logic [1:0] {IDLE, DIV, EMIT} centroid_state_t;
  localparam logic [2:0] F_RMIN = 3'd0;
  localparam logic [2:0] F_RMAX = 3'd1;
  localparam logic [2:0] F_GMIN = 3'd2;
  localparam logic [2:0] F_GMAX = 3'd3;
  localparam logic [2:0] F_BMIN = 3'd4;
  localparam logic [2:0] F_BMAX = 3'd5;
  localparam rgb_thresh_t THR_RESET = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000};
  function automatic int chWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic inWindow(input logic [11:0] v, input logic [11:0] lo, input logic [11:0] hi);
    return v >= lo && v <= hi;
  endfunction
endpackage

// File: rtl/centroid_div.sv
// centroid_div: restoring unsigned divider, first step taken in the start cycle, quotient saturates at 2047
module centroid_div #(
  parameter int SUM_W = 30,
  parameter int CNT_W = 19
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic [SUM_W-1:0] iNUM,
  input  logic [CNT_W-1:0] iDEN,
  output logic [10:0]      oQ,
  output logic             oDONE
);
  localparam int STEP_W = $clog2(SUM_W + 1);
  logic [CNT_W-1:0] rem, den, srcRem, srcDen, nextRem;
  logic [SUM_W-1:0] quo, srcQuo, nextQuo;
  logic [CNT_W:0] trial, diff;
  logic [STEP_W-1:0] steps;
  logic busy, ge;
  // one restoring step, fed from the inputs on start so the load cycle does useful work
  always_comb begin
    srcRem = iSTART ? '0 : rem;
    srcQuo = iSTART ? iNUM : quo;
    srcDen = iSTART ? iDEN : den;
    trial = {srcRem, srcQuo[SUM_W-1]};
    diff = trial - {1'b0, srcDen};
    ge = trial >= {1'b0, srcDen};
    nextRem = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
    nextQuo = {srcQuo[SUM_W-2:0], ge};
  end
  // iterate SUM_W steps in total, then flag done for one cycle
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rem <= '0;
      quo <= '0;
      den <= '0;
      steps <= '0;
      busy <= 1'b0;
      oDONE <= 1'b0;
    end else begin
      oDONE <= busy && steps == STEP_W'(1);
      if (iSTART) begin
        rem <= nextRem;
        quo <= nextQuo;
        den <= iDEN;
        steps <= STEP_W'(SUM_W - 1);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= nextRem;
        quo <= nextQuo;
        steps <= steps - 1'b1;
        busy <= steps != STEP_W'(1);
      end
    end
  end
  assign oQ = |quo[SUM_W-1:11] ? 11'h7FF : quo[10:0];
endmodule

// File: rtl/ipu_multi_centroid.sv
// ipu_multi_centroid: per-channel RGB window classification, frame accumulation and centroid readout
module ipu_multi_centroid
  import ipu_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int MIN_PIX = 16,
  localparam int CH_W = chWidth(NUM_CH),
  localparam int CNT_W = $clog2(FRAME_W * FRAME_H + 1),
  localparam int SUM_W = CNT_W + 11
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [11:0]      iRed,
  input  logic [11:0]      iGreen,
  input  logic [11:0]      iBlue,
  input  logic [10:0]      iX_Cont,
  input  logic [10:0]      iY_Cont,
  input  logic             iCFG_WE,
  input  logic [CH_W+2:0]  iCFG_ADDR,
  input  logic [11:0]      iCFG_DATA,
  output logic [10:0]      oX,
  output logic [10:0]      oY,
  output logic [CNT_W-1:0] oCOUNT,
  output logic [CH_W-1:0]  oCH,
  output logic             oFOUND,
  output logic             oDVAL,
  input  logic             iREADY,
  output logic             oOVERRUN
);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  rgb_thresh_t thr [NUM_CH];
  logic [NUM_CH-1:0] matchQ;
  logic pixQ, fvalQ, snapPend;
  logic [10:0] xQ, yQ;
  logic [CNT_W-1:0] accCnt [NUM_CH];
  logic [CNT_W-1:0] resCnt [NUM_CH];
  logic [SUM_W-1:0] accX [NUM_CH];
  logic [SUM_W-1:0] accY [NUM_CH];
  logic [SUM_W-1:0] resSumX [NUM_CH];
  logic [SUM_W-1:0] resSumY [NUM_CH];
  logic [10:0] cenX [NUM_CH];
  logic [10:0] cenY [NUM_CH];
  centroid_state_t state;
  logic [CH_W-1:0] chIdx, recIdx, cfgCh;
  logic [2:0] cfgField;
  logic phaseY, divBusy, divStart, divDone, lastCh, recFound;
  logic [SUM_W-1:0] divNum;
  logic [10:0] divQ, recX, recY;
  function automatic logic enough(input logic [CNT_W-1:0] n);
    return n != '0 && n >= CNT_W'(MIN_PIX);
  endfunction
  // address decode, divider feed and the next record to present
  always_comb begin
    cfgCh = iCFG_ADDR[CH_W+2:3];
    cfgField = iCFG_ADDR[2:0];
    lastCh = chIdx == LAST_CH;
    divStart = state == DIV && !divBusy && enough(resCnt[chIdx]);
    divNum = phaseY ? resSumY[chIdx] : resSumX[chIdx];
    recIdx = state == EMIT ? chIdx + 1'b1 : '0;
    recFound = enough(resCnt[recIdx]);
    recX = recFound ? cenX[recIdx] : '0;
    recY = !recFound ? '0 : (state == DIV && recIdx == chIdx) ? divQ : cenY[recIdx];
  end
  // threshold register file; channels beyond NUM_CH and fields 6/7 are never written
  always_ff @(posedge iCLK) begin
    for (int c = 0; c < NUM_CH; c++)
      if (iRST) thr[c] <= THR_RESET;
      else if (iCFG_WE && int'(cfgCh) == c)
        case (cfgField)
          F_RMIN: thr[c].Rmin <= iCFG_DATA;
          F_RMAX: thr[c].Rmax <= iCFG_DATA;
          F_GMIN: thr[c].Gmin <= iCFG_DATA;
          F_GMAX: thr[c].Gmax <= iCFG_DATA;
          F_BMIN: thr[c].Bmin <= iCFG_DATA;
          F_BMAX: thr[c].Bmax <= iCFG_DATA;
          default: ;
        endcase
  end
  // register the per-channel window match with its coordinates, and detect frame edges
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pixQ <= 1'b0;
      matchQ <= '0;
      xQ <= '0;
      yQ <= '0;
      fvalQ <= 1'b0;
      snapPend <= 1'b0;
    end else begin
      pixQ <= iFVAL & iDVAL;
      xQ <= iX_Cont;
      yQ <= iY_Cont;
      fvalQ <= iFVAL;
      snapPend <= fvalQ & ~iFVAL;
      for (int c = 0; c < NUM_CH; c++)
        matchQ[c] <= inWindow(iRed, thr[c].Rmin, thr[c].Rmax) && inWindow(iGreen, thr[c].Gmin, thr[c].Gmax) && inWindow(iBlue, thr[c].Bmin, thr[c].Bmax);
    end
  end
  // frame accumulators, cleared on frame start
  always_ff @(posedge iCLK) begin
    for (int c = 0; c < NUM_CH; c++)
      if (iRST || (iFVAL && !fvalQ)) begin
        accCnt[c] <= '0;
        accX[c] <= '0;
        accY[c] <= '0;
      end else if (pixQ && matchQ[c]) begin
        accCnt[c] <= accCnt[c] + 1'b1;
        accX[c] <= accX[c] + SUM_W'(xQ);
        accY[c] <= accY[c] + SUM_W'(yQ);
      end
  end
  centroid_div #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div (
    .iCLK(iCLK),
    .iRST(iRST),
    .iSTART(divStart),
    .iNUM(divNum),
    .iDEN(resCnt[chIdx]),
    .oQ(divQ),
    .oDONE(divDone)
  );
  // snapshot at frame end, divide channel by channel, then hand records out in order
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
      chIdx <= '0;
      phaseY <= 1'b0;
      divBusy <= 1'b0;
      resCnt <= '{default: '0};
      resSumX <= '{default: '0};
      resSumY <= '{default: '0};
      cenX <= '{default: '0};
      cenY <= '{default: '0};
      oX <= '0;
      oY <= '0;
      oCOUNT <= '0;
      oCH <= '0;
      oFOUND <= 1'b0;
      oDVAL <= 1'b0;
      oOVERRUN <= 1'b0;
    end else begin
      oOVERRUN <= snapPend && state != IDLE;
      case (state)
        IDLE: if (snapPend) begin
          resCnt <= accCnt;
          resSumX <= accX;
          resSumY <= accY;
          chIdx <= '0;
          phaseY <= 1'b0;
          state <= DIV;
        end
        DIV: if (divStart) divBusy <= 1'b1;
        else if (!divBusy || divDone) begin
          divBusy <= 1'b0;
          phaseY <= divBusy && !phaseY;
          if (divBusy && !phaseY) cenX[chIdx] <= divQ;
          if (divBusy && phaseY) cenY[chIdx] <= divQ;
          if (!divBusy || phaseY) begin
            chIdx <= lastCh ? '0 : chIdx + 1'b1;
            if (lastCh) begin
              state <= EMIT;
              oDVAL <= 1'b1;
              oX <= recX;
              oY <= recY;
              oCOUNT <= resCnt[recIdx];
              oCH <= recIdx;
              oFOUND <= recFound;
            end
          end
        end
        EMIT: if (iREADY) begin
          oDVAL <= !lastCh;
          chIdx <= lastCh ? '0 : chIdx + 1'b1;
          state <= lastCh ? IDLE : EMIT;
          if (!lastCh) begin
            oX <= recX;
            oY <= recY;
            oCOUNT <= resCnt[recIdx];
            oCH <= recIdx;
            oFOUND <= recFound;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipu_multi_centroid.sv
// tb_ipu_multi_centroid: scoreboard bench for the multi-channel centroid block
module tb_ipu_multi_centroid;
  localparam int NCH = 4;
  localparam int FW = 128;
  localparam int FH = 64;
  localparam int MINP = 16;
  localparam int CH_W = 2;
  localparam int CNT_W = $clog2(FW * FH + 1);
  localparam int SUM_W = CNT_W + 11;
  localparam int LAT = 2 + NCH * 2 * (SUM_W + 1);
  typedef struct {
    int ch;
    int cnt;
    int x;
    int y;
    int found;
  } rec_t;
  logic iCLK = 0, iRST = 1, iFVAL = 0, iDVAL = 0, iCFG_WE = 0, iREADY = 1;
  logic [11:0] iRed = 0, iGreen = 0, iBlue = 0, iCFG_DATA = 0;
  logic [10:0] iX_Cont = 0, iY_Cont = 0;
  logic [CH_W+2:0] iCFG_ADDR = 0;
  logic [10:0] oX, oY;
  logic [CNT_W-1:0] oCOUNT;
  logic [CH_W-1:0] oCH;
  logic oFOUND, oDVAL, oOVERRUN;
  rec_t sb[$];
  rec_t r;
  int errors = 0, checks = 0, handshakes = 0, overruns = 0;
  int tMin[NCH][3];
  int tMax[NCH][3];
  longint aC[NCH], aX[NCH], aY[NCH];

  always #5 iCLK = ~iCLK;

  ipu_multi_centroid #(.NUM_CH(NCH), .FRAME_W(FW), .FRAME_H(FH), .MIN_PIX(MINP)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iCFG_WE(iCFG_WE), .iCFG_ADDR(iCFG_ADDR), .iCFG_DATA(iCFG_DATA),
    .oX(oX), .oY(oY), .oCOUNT(oCOUNT), .oCH(oCH), .oFOUND(oFOUND), .oDVAL(oDVAL),
    .iREADY(iREADY), .oOVERRUN(oOVERRUN)
  );

  task automatic chk(input string tag, input logic [63:0] got, input longint exp);
    checks++;
    if (got !== 64'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // pop and compare on every handshake, count overrun pulses
  always @(negedge iCLK) begin
    if (oOVERRUN) overruns++;
    if (oDVAL && iREADY) begin
      handshakes++;
      if (sb.size() == 0) chk("queue_has_entry", sb.size(), 1);
      else begin
        r = sb.pop_front();
        chk("rec_ch", oCH, r.ch);
        chk("rec_count", oCOUNT, r.cnt);
        chk("rec_found", oFOUND, r.found);
        chk("rec_x", oX, r.x);
        chk("rec_y", oY, r.y);
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic resetModel();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 3; k++) begin
        tMin[c][k] = 4095;
        tMax[c][k] = 0;
      end
  endtask

  task automatic cfg(input int ch, input int f, input int d);
    iCFG_WE = 1;
    iCFG_ADDR = (CH_W + 3)'(ch * 8 + f);
    iCFG_DATA = 12'(d);
    tick();
    iCFG_WE = 0;
    if (ch < NCH && f < 6) begin
      if (f % 2 == 0) tMin[ch][f / 2] = d;
      else tMax[ch][f / 2] = d;
    end
  endtask

  task automatic window(input int ch, input int rl, input int rh, input int gl, input int gh, input int bl, input int bh);
    cfg(ch, 0, rl); cfg(ch, 1, rh); cfg(ch, 2, gl); cfg(ch, 3, gh); cfg(ch, 4, bl); cfg(ch, 5, bh);
  endtask

  task automatic startFrame();
    for (int c = 0; c < NCH; c++) begin
      aC[c] = 0;
      aX[c] = 0;
      aY[c] = 0;
    end
    iFVAL = 1;
    tick();
  endtask

  task automatic pix(input int x, input int y, input int rv, input int gv, input int bv);
    int v[3];
    bit m;
    v[0] = rv; v[1] = gv; v[2] = bv;
    iDVAL = 1;
    iX_Cont = 11'(x); iY_Cont = 11'(y);
    iRed = 12'(rv); iGreen = 12'(gv); iBlue = 12'(bv);
    tick();
    iDVAL = 0;
    for (int c = 0; c < NCH; c++) begin
      m = 1;
      for (int k = 0; k < 3; k++) if (v[k] < tMin[c][k] || v[k] > tMax[c][k]) m = 0;
      if (m) begin
        aC[c]++;
        aX[c] += x;
        aY[c] += y;
      end
    end
  endtask

  task automatic square(input int x0, input int y0, input int n);
    for (int y = y0; y < y0 + n; y++)
      for (int x = x0; x < x0 + n; x++)
        pix(x, y, (x == x0) ? 3000 : 4095, (y == y0) ? 500 : 0, 0);
  endtask

  task automatic endFrame(input bit keep);
    rec_t e;
    iDVAL = 0;
    iFVAL = 0;
    tick();
    if (keep)
      for (int c = 0; c < NCH; c++) begin
        e.ch = c;
        e.cnt = int'(aC[c]);
        e.found = (aC[c] >= MINP) ? 1 : 0;
        e.x = e.found ? int'(aX[c] / aC[c]) : 0;
        e.y = e.found ? int'(aY[c] / aC[c]) : 0;
        if (e.x > 2047) e.x = 2047;
        if (e.y > 2047) e.y = 2047;
        sb.push_back(e);
      end
  endtask

  task automatic waitDval(input int lim);
    int n = 0;
    while (!oDVAL && n < lim) begin
      tick();
      n++;
    end
    chk("dval_within_latency", oDVAL, 1);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (sb.size() != 0 && n < lim) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk("queue_drained", sb.size(), 0);
  endtask

  task automatic checkZero(input string tag);
    @(negedge iCLK);
    chk({tag, "_x"}, oX, 0);
    chk({tag, "_y"}, oY, 0);
    chk({tag, "_count"}, oCOUNT, 0);
    chk({tag, "_ch"}, oCH, 0);
    chk({tag, "_found"}, oFOUND, 0);
    chk({tag, "_dval"}, oDVAL, 0);
    chk({tag, "_overrun"}, oOVERRUN, 0);
  endtask

  initial begin
    int h0, ov0;
    resetModel();
    repeat (3) tick();
    checkZero("reset");
    tick();
    iRST = 0;
    tick();

    startFrame();
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) pix(x, y, 4095, 4095, 4095);
    endFrame(1);
    drain(LAT + 50);

    window(0, 3000, 4095, 0, 500, 0, 500);
    cfg(0, 6, 0);
    cfg(0, 7, 0);
    cfg(1, 6, 4095);
    startFrame();
    pix(5, 5, 2999, 0, 0);
    pix(6, 5, 4095, 501, 0);
    square(100, 50, 4);
    endFrame(1);
    drain(LAT + 50);

    iREADY = 0;
    h0 = handshakes;
    startFrame();
    square(100, 50, 4);
    endFrame(1);
    waitDval(LAT);
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      chk("hold_dval", oDVAL, 1);
      chk("hold_ch", oCH, sb[0].ch);
      chk("hold_count", oCOUNT, sb[0].cnt);
      chk("hold_x", oX, sb[0].x);
      chk("hold_y", oY, sb[0].y);
    end
    tick();
    iREADY = 1;
    drain(LAT + 50);
    chk("stall_handshakes", handshakes - h0, NCH);

    window(2, 2000, 4095, 0, 1000, 0, 1000);
    startFrame();
    square(10, 10, 3);
    endFrame(1);
    drain(LAT + 50);

    iREADY = 0;
    startFrame();
    square(100, 50, 4);
    endFrame(1);
    waitDval(LAT);
    ov0 = overruns;
    startFrame();
    square(20, 20, 5);
    endFrame(0);
    repeat (6) tick();
    chk("overrun_pulses", overruns - ov0, 1);
    iREADY = 1;
    drain(LAT + 50);

    startFrame();
    square(100, 50, 4);
    endFrame(0);
    repeat (8) tick();
    iRST = 1;
    tick();
    iRST = 0;
    checkZero("abort");
    resetModel();
    tick();
    window(0, 3000, 4095, 0, 500, 0, 500);
    startFrame();
    square(60, 30, 5);
    endFrame(1);
    drain(LAT + 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
